fetch_seq: RTL and testbench
============================

FETCH_SEQ -- requirements
Module: fetch_seq

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_3000, SHALL be the first fetch address after reset.
REQ-002 Parameter TIMEOUT, default 16, SHALL be the number of WAIT cycles without imem_rvalid before a retry.
REQ-003 clk  in  1  SHALL be the single clock; all state updates on its rising edge.
REQ-004 reset_n  in  1  SHALL be the asynchronous, active-low reset.
REQ-005 stall  in  1  SHALL be the hazard-unit hold: IF output is not consumed while 1.
REQ-006 redirect_valid  in  1  SHALL be the branch/jump-taken select (nPCSel) from the next-PC logic.
REQ-007 redirect_pc  in  32  SHALL be the branch/jump target (nPCAlt), applied after the delay slot.
REQ-008 imem_req  out  1  SHALL be the instruction-memory request strobe.
REQ-009 imem_addr  out  32  SHALL be the word-aligned fetch address.
REQ-010 imem_ready  in  1  SHALL be the memory acceptance of the current request.
REQ-011 imem_rvalid  in  1, imem_rdata  in  32  SHALL be the returned instruction and its strobe.
REQ-012 if_valid  out  1, if_pc  out  32, if_instr  out  32  SHALL be the fetched instruction presented to ID.
REQ-013 misalign_err  out  1  SHALL pulse for one cycle when a redirect target has nonzero bits [1:0].
REQ-014 fetch_err  out  1  SHALL be sticky until reset once any timeout occurs.

Function
REQ-015 The FSM SHALL have states IDLE, REQ, WAIT and OUT, with at most one outstanding request.
REQ-016 IDLE SHALL last exactly one cycle after reset release, then go to REQ.
REQ-017 In REQ, imem_req SHALL be 1 and imem_addr SHALL equal pc_r; on imem_ready=1 the FSM SHALL record req_pc=pc_r and go to WAIT.
REQ-018 In WAIT, imem_req SHALL be 0; on imem_rvalid=1 the block SHALL capture if_instr=imem_rdata and if_pc=req_pc, then go to OUT.
REQ-019 On that capture edge, pc_r SHALL become redirect_pc if redirect_valid=1, else pend_pc if pend=1, else req_pc+4; pend SHALL clear.
REQ-020 In OUT, if_valid SHALL be 1; while stall=1, if_valid, if_pc and if_instr SHALL hold; on a cycle with stall=0 the FSM SHALL go to REQ.
REQ-021 Outside OUT, if_valid SHALL be 0.
REQ-022 Throughput SHALL be one instruction per 3 cycles with zero-wait memory (REQ, WAIT, OUT); the first if_valid SHALL appear 3 cycles after leaving IDLE.
REQ-023 redirect_valid=1 in any state other than a WAIT capture edge SHALL set pend=1 and pend_pc=redirect_pc; a later redirect SHALL overwrite an earlier one (newest wins).
REQ-024 A redirect SHALL never cancel the instruction already requested or held; that instruction is the delay slot and SHALL be delivered.
REQ-025 Redirect targets SHALL be used with bits [1:0] forced to 0, and misalign_err SHALL pulse on the cycle the target is latched or applied.
REQ-026 The WAIT cycle counter SHALL reset on entry to WAIT; when it reaches TIMEOUT, the FSM SHALL return to REQ with the same pc_r and set fetch_err.
REQ-027 imem_rvalid outside WAIT SHALL be ignored.
REQ-028 pc_r+4 SHALL wrap modulo 2^32.

Reset
REQ-029 While reset_n=0: state=IDLE, pc_r=RESET_PC, req_pc=RESET_PC, pend=0, pend_pc=0, imem_req=0, imem_addr=RESET_PC, if_valid=0, if_pc=0, if_instr=0, misalign_err=0, fetch_err=0, timeout counter=0.
REQ-030 Reset asserted mid-transaction SHALL abandon the outstanding request, and a late imem_rvalid after release SHALL be ignored per REQ-027.

Structure
REQ-031 Package fetch_pkg SHALL hold the state enumeration, the RESET_PC default and the TIMEOUT default.
REQ-032 The pend/pend_pc register and the target-select mux SHALL be one sub-module, fetch_redirect_buf; everything else SHALL be in fetch_seq.

Verification
REQ-033 Reset release, zero-wait memory returning 0x1111_0000+addr, stall=0 -> imem_addr sequence 0x3000, 0x3004, 0x3008, with if_valid once every 3 cycles and if_pc matching each address.
REQ-034 Branch in ID: redirect_valid=1 with redirect_pc=0x3100 while fetching 0x3008 -> 0x3008 is delivered, then the next imem_addr is 0x3100.
REQ-035 stall=1 for 5 cycles in OUT with if_pc=0x3004 -> if_valid, if_pc and if_instr are stable for all 5 cycles and no imem_req is issued.
REQ-036 Two redirects, 0x4000 then 0x5000, before the capture edge -> the next fetch is 0x5000; redirect_pc=0x4002 -> fetch 0x4000 and a one-cycle misalign_err pulse.
REQ-037 imem_rvalid withheld for 16 WAIT cycles -> re-request at the same address and fetch_err=1 until reset.
REQ-038 reset_n dropped during WAIT, with rvalid arriving 1 cycle after release -> rvalid is ignored, if_valid=0 and the first fetch is 0x3000.

Source files
------------

// File: rtl/fetch_pkg.sv
// fetch_pkg: state encoding and parameter defaults shared by the fetch sequencer
package fetch_pkg;
    typedef enum logic [1:0] {IDLE, REQ, WAIT, OUT} state_t;
    localparam logic [31:0] RESET_PC_DEF = 32'h0000_3000;
    localparam int unsigned TIMEOUT_DEF  = 16;
endpackage

// File: rtl/fetch_redirect_buf.sv
// fetch_redirect_buf: holds the newest pending redirect and selects the pc loaded on capture
module fetch_redirect_buf (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    input  logic        capture,
    input  logic [31:0] req_pc,
    output logic [31:0] next_pc
);
    logic        pend;
    logic [31:0] pend_pc;
    logic [31:0] target;
    assign target  = {redirect_pc[31:2], 2'b00};
    assign next_pc = redirect_valid ? target : pend ? pend_pc : req_pc + 32'd4;
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            pend    <= 1'b0;
            pend_pc <= '0;
        end else if (capture) begin
            pend    <= 1'b0;
        end else if (redirect_valid) begin
            pend    <= 1'b1;
            pend_pc <= target;
        end
    end
endmodule

// File: rtl/fetch_seq.sv
// fetch_seq: single-outstanding instruction fetch FSM with delay-slot redirects and retry on timeout
module fetch_seq
    import fetch_pkg::*;
#(
    parameter logic [31:0] RESET_PC = RESET_PC_DEF,
    parameter int unsigned TIMEOUT  = TIMEOUT_DEF
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        stall,
    input  logic        redirect_valid,
    input  logic [31:0] redirect_pc,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        if_valid,
    output logic [31:0] if_pc,
    output logic [31:0] if_instr,
    output logic        misalign_err,
    output logic        fetch_err
);
    state_t      state, state_nx;
    logic [31:0] pc_r, req_pc, next_pc;
    logic [15:0] cnt;
    logic        capture, timeout;

    assign capture   = state == WAIT && imem_rvalid;
    assign timeout   = state == WAIT && !imem_rvalid && cnt == 16'(TIMEOUT - 1);
    assign imem_req  = state == REQ;
    assign imem_addr = pc_r;
    assign if_valid  = state == OUT;

    fetch_redirect_buf u_redirect (
        .clk            (clk),
        .reset_n        (reset_n),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .capture        (capture),
        .req_pc         (req_pc),
        .next_pc        (next_pc)
    );

    always_comb begin
        state_nx = (state == IDLE)                     ? REQ  :
                   (state == REQ && imem_ready)        ? WAIT :
                   capture                             ? OUT  :
                   (timeout || (state == OUT && !stall)) ? REQ  : state;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state        <= IDLE;
            pc_r         <= RESET_PC;
            req_pc       <= RESET_PC;
            cnt          <= '0;
            if_pc        <= '0;
            if_instr     <= '0;
            misalign_err <= 1'b0;
            fetch_err    <= 1'b0;
        end else begin
            state        <= state_nx;
            misalign_err <= redirect_valid && |redirect_pc[1:0];
            if (state == REQ && imem_ready) begin
                req_pc <= pc_r;
                cnt    <= '0;
            end else if (state == WAIT && !capture) begin
                cnt    <= cnt + 16'd1;
            end
            // the delay-slot instruction is always delivered; redirects only steer the next pc
            if (capture) begin
                if_pc    <= req_pc;
                if_instr <= imem_rdata;
                pc_r     <= next_pc;
            end
            if (timeout) fetch_err <= 1'b1;
        end
    end
endmodule

// File: tb/tb_fetch_seq.sv
// tb_fetch_seq: directed stimulus with a queue scoreboard for requests and delivered instructions
module tb_fetch_seq;
    logic        clk = 1'b0, reset_n = 1'b0, stall = 1'b0, redirect_valid = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic        imem_req, imem_ready = 1'b0, imem_rvalid;
    logic [31:0] imem_addr, imem_rdata, if_pc, if_instr;
    logic        if_valid, misalign_err, fetch_err;
    logic        mem_rv = 1'b0, inj_rv = 1'b0;
    logic [31:0] mem_data = '0, inj_data = '0;
    int          checks = 0, failures = 0;
    int          allow = 0, accepted = 0, lat = 0;
    logic [31:0] exp_addr[$];
    logic [63:0] exp_out[$];

    assign imem_rvalid = mem_rv | inj_rv;
    assign imem_rdata  = mem_rv ? mem_data : inj_data;

    fetch_seq dut (
        .clk            (clk),
        .reset_n        (reset_n),
        .stall          (stall),
        .redirect_valid (redirect_valid),
        .redirect_pc    (redirect_pc),
        .imem_req       (imem_req),
        .imem_addr      (imem_addr),
        .imem_ready     (imem_ready),
        .imem_rvalid    (imem_rvalid),
        .imem_rdata     (imem_rdata),
        .if_valid       (if_valid),
        .if_pc          (if_pc),
        .if_instr       (if_instr),
        .misalign_err   (misalign_err),
        .fetch_err      (fetch_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input logic [31:0] v);
        checks++;
        failures++;
        $display("FAIL %s: unexpected or missing event, value %0h", name, v);
    endtask

    task automatic step();
        @(posedge clk);
        #2;
    endtask

    task automatic grant(input int n);
        allow = accepted + n;
    endtask

    task automatic expect_fetch(input logic [31:0] pc);
        exp_addr.push_back(pc);
        exp_out.push_back({pc, 32'h1111_0000 + pc});
    endtask

    task automatic drain(input string name);
        check(name, 128'(exp_addr.size() + exp_out.size()), 128'(0));
    endtask

    task automatic do_reset();
        reset_n = 1'b0;
        stall = 1'b0;
        redirect_valid = 1'b0;
        redirect_pc = '0;
        lat = 0;
        inj_rv = 1'b0;
        step();
        step();
    endtask

    task automatic wait_out(input logic [31:0] pc);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(if_valid && if_pc == pc) && n < 60);
        if (!(if_valid && if_pc == pc)) flag("wait_out", pc);
    endtask

    task automatic wait_req(input logic [31:0] a);
        int n = 0;
        do begin @(negedge clk); n++; end while (!(imem_req && imem_addr == a) && n < 60);
        if (!(imem_req && imem_addr == a)) flag("wait_req", a);
    endtask

    // memory: accepts per grant budget, answers after 'lat' extra WAIT cycles, forgets on reset
    initial begin
        logic        acc;
        logic [31:0] a, ma;
        int          mc;
        bit          pm;
        acc = 1'b0; a = '0; ma = '0; mc = 0; pm = 1'b0;
        forever begin
            @(negedge clk);
            acc = reset_n && imem_req && imem_ready;
            a   = imem_addr;
            @(posedge clk);
            #1;
            mem_rv = 1'b0;
            if (!reset_n) pm = 1'b0;
            else if (acc) begin pm = 1'b1; ma = a; mc = lat; accepted++; end
            else if (pm && mc > 0) mc--;
            if (pm && mc == 0) begin
                mem_rv   = 1'b1;
                mem_data = 32'h1111_0000 + ma;
                pm       = 1'b0;
            end
            imem_ready = accepted < allow;
        end
    end

    initial forever begin
        @(negedge clk);
        if (reset_n && imem_req && imem_ready) begin
            if (exp_addr.size() == 0) flag("req_extra", imem_addr);
            else check("req_addr", 128'(imem_addr), 128'(exp_addr.pop_front()));
        end
        if (reset_n && if_valid && !stall) begin
            if (exp_out.size() == 0) flag("if_extra", if_pc);
            else check("if_out", 128'({if_pc, if_instr}), 128'(exp_out.pop_front()));
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, vcount, nreq;
        logic r1, fe0;
        first = 0; vcount = 0; nreq = 0; r1 = 1'b0; fe0 = 1'b0;
        // reset state and basic sequential fetch
        step();
        step();
        check("rst_ctrl", 128'({imem_req, if_valid, misalign_err, fetch_err}), 128'(0));
        check("rst_addr", 128'(imem_addr), 128'(32'h3000));
        check("rst_if", 128'({if_pc, if_instr}), 128'(0));
        expect_fetch(32'h3000);
        expect_fetch(32'h3004);
        expect_fetch(32'h3008);
        grant(3);
        step();
        reset_n = 1'b1;
        @(negedge clk);
        check("idle_cycle", 128'({imem_req, if_valid}), 128'(0));
        for (int i = 1; i <= 11; i++) begin
            @(negedge clk);
            if (i == 1) r1 = imem_req;
            if (if_valid && first == 0) first = i;
            if (i >= 3 && if_valid) vcount++;
        end
        check("req_after_idle", 128'(r1), 128'(1));
        check("first_valid_cycle", 128'(first), 128'(3));
        check("valid_every_3", 128'(vcount), 128'(3));
        drain("t1_drain");

        // redirect while fetching 0x3008 goes through the pending buffer
        do_reset();
        expect_fetch(32'h3000);
        expect_fetch(32'h3004);
        expect_fetch(32'h3008);
        expect_fetch(32'h3100);
        grant(4);
        step();
        reset_n = 1'b1;
        wait_out(32'h3004);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h3100;
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("aligned_no_misalign", 128'(misalign_err), 128'(0));
        wait_out(32'h3100);
        step();
        drain("t2_drain");

        // stall holds OUT for 5 cycles
        do_reset();
        expect_fetch(32'h3000);
        expect_fetch(32'h3004);
        expect_fetch(32'h3008);
        grant(3);
        step();
        reset_n = 1'b1;
        wait_req(32'h3004);
        step();
        stall = 1'b1;
        step();
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            check("stall_hold", 128'({if_valid, imem_req, if_pc, if_instr}),
                  128'({1'b1, 1'b0, 32'h3004, 32'h1111_3004}));
            step();
        end
        stall = 1'b0;
        wait_out(32'h3008);
        step();
        drain("t3_drain");

        // newest of two redirects wins, second lands during a slow WAIT
        do_reset();
        expect_fetch(32'h3000);
        expect_fetch(32'h3004);
        expect_fetch(32'h5000);
        grant(3);
        step();
        reset_n = 1'b1;
        wait_out(32'h3000);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h4000;
        lat = 2;
        step();
        redirect_pc = 32'h5000;
        lat = 0;
        step();
        redirect_valid = 1'b0;
        wait_out(32'h5000);
        step();
        drain("t4_drain");

        // misaligned target is truncated and flagged for one cycle
        do_reset();
        expect_fetch(32'h3000);
        expect_fetch(32'h3004);
        expect_fetch(32'h4000);
        grant(3);
        step();
        reset_n = 1'b1;
        wait_out(32'h3000);
        step();
        redirect_valid = 1'b1;
        redirect_pc = 32'h4002;
        @(negedge clk);
        check("misalign_before", 128'(misalign_err), 128'(0));
        step();
        redirect_valid = 1'b0;
        @(negedge clk);
        check("misalign_pulse", 128'(misalign_err), 128'(1));
        step();
        @(negedge clk);
        check("misalign_after", 128'(misalign_err), 128'(0));
        wait_out(32'h4000);
        step();
        drain("t5_drain");

        // timeout: 16 silent WAIT cycles, re-request same address, sticky fetch_err
        do_reset();
        lat = 100;
        exp_addr.push_back(32'h3000);
        expect_fetch(32'h3000);
        grant(2);
        step();
        reset_n = 1'b1;
        wait_req(32'h3000);
        step();
        lat = 0;
        for (int i = 0; i < 16; i++) begin
            @(negedge clk);
            if (i == 0) fe0 = fetch_err;
            if (imem_req) nreq++;
        end
        check("fetch_err_before", 128'(fe0), 128'(0));
        check("wait_quiet", 128'(nreq), 128'(0));
        @(negedge clk);
        check("timeout_rereq", 128'({imem_req, imem_addr, fetch_err}), 128'({1'b1, 32'h3000, 1'b1}));
        wait_out(32'h3000);
        step();
        check("fetch_err_sticky", 128'(fetch_err), 128'(1));
        drain("t6_drain");
        do_reset();
        check("fetch_err_cleared", 128'(fetch_err), 128'(0));

        // reset during WAIT abandons the request; a late rvalid is ignored
        lat = 100;
        exp_addr.push_back(32'h3000);
        grant(1);
        step();
        reset_n = 1'b1;
        wait_req(32'h3000);
        step();
        reset_n = 1'b0;
        step();
        step();
        lat = 0;
        expect_fetch(32'h3000);
        grant(1);
        inj_data = 32'hDEAD_BEEF;
        reset_n = 1'b1;
        step();
        inj_rv = 1'b1;
        @(negedge clk);
        check("late_rvalid_ignored", 128'({if_valid, imem_req, imem_addr}), 128'({1'b0, 1'b1, 32'h3000}));
        step();
        inj_rv = 1'b0;
        wait_out(32'h3000);
        step();
        drain("t7_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
